// File: rtl/fibo_pkg.sv
// fibo_pkg
// Shared definitions for the Fibonacci sequencing controller: the ALU opcode
// constants it issues and the controller FSM state encoding.
package fibo_pkg;

  // Opcodes understood by the downstream ALU.
  localparam logic [2:0] OP_LOAD1 = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_PASSA = 3'b100;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    TEST = 3'd2,
    SUM  = 3'd3,
    DEC  = 3'd4,
    DONE = 3'd5
  } fibo_state_e;

endpackage

// File: rtl/fibo_ctrl.sv
// fibo_ctrl
// Sequencing controller computing F(n) mod 2^size by steering an external ALU.
// The controller does no arithmetic itself: every sum, decrement and zero test
// is requested from the ALU through alu_opcode/alu_a/alu_b and the answer is
// taken back on alu_d/alu_zero.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - request a computation (honoured only in IDLE)
//   n          - Fibonacci index, captured with start
//   alu_d      - ALU result
//   alu_zero   - ALU zero flag
//   alu_opcode - opcode to the ALU, decoded from the state
//   alu_a      - ALU operand A
//   alu_b      - ALU operand B
//   busy       - high whenever the FSM is not in IDLE
//   done       - one-cycle pulse when result becomes valid
//   result     - F(n) mod 2^size, held until the next accepted start
//   ovf        - (only with FIBO_OVF_EN) result has wrapped
//
// Configuration macro: FIBO_OVF_EN adds the ovf port and wrap tracking.
module fibo_ctrl
  import fibo_pkg::*;
#(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] n,
  input  logic [size-1:0] alu_d,
  input  logic            alu_zero,
  output logic [2:0]      alu_opcode,
  output logic [size-1:0] alu_a,
  output logic [size-1:0] alu_b,
  output logic            busy,
  output logic            done,
`ifdef FIBO_OVF_EN
  output logic [size-1:0] result,
  output logic            ovf
`else
  output logic [size-1:0] result
`endif
);

  fibo_state_e state_q, state_d;

  logic [size-1:0] cnt_q, cnt_d;
  logic [size-1:0] prev_q, prev_d;
  logic [size-1:0] cur_q, cur_d;
  logic [size-1:0] result_q, result_d;

`ifdef FIBO_OVF_EN
  logic cur_wrap_q, cur_wrap_d;
  logic prev_wrap_q, prev_wrap_d;
  logic ovf_q, ovf_d;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Loop exits from TEST once the ALU reports cnt == 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = TEST;
      TEST:    state_d = alu_zero ? DONE : SUM;
      SUM:     state_d = DEC;
      DEC:     state_d = TEST;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode. A=cnt, B=cur unless the step needs something else.
  always_comb begin
    alu_opcode = OP_PASSA;
    alu_a      = cnt_q;
    alu_b      = cur_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    case (state_q)
      LOAD: alu_opcode = OP_LOAD1;
      SUM: begin
        alu_opcode = OP_ADD;
        alu_a      = prev_q;
      end
      DEC:  alu_opcode = OP_DEC;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state. cur always runs one Fibonacci term ahead of prev, so
  // when cnt reaches zero prev already holds F(n).
  always_comb begin
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    cur_d    = cur_q;
    result_d = result_q;
`ifdef FIBO_OVF_EN
    cur_wrap_d  = cur_wrap_q;
    prev_wrap_d = prev_wrap_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = n;
          prev_d = '0;
`ifdef FIBO_OVF_EN
          cur_wrap_d  = 1'b0;
          prev_wrap_d = 1'b0;
`endif
        end
      end
      LOAD: cur_d = alu_d;
      TEST: begin
        if (alu_zero) begin
          result_d = prev_q;
`ifdef FIBO_OVF_EN
          ovf_d = prev_wrap_q;
`endif
        end
      end
      SUM: begin
        prev_d = cur_q;
        cur_d  = alu_d;
`ifdef FIBO_OVF_EN
        // A modular sum smaller than an addend means the add carried out.
        // The wrap flag follows its term as it moves from cur into prev.
        cur_wrap_d  = cur_wrap_q | (alu_d < prev_q);
        prev_wrap_d = cur_wrap_q;
`endif
      end
      DEC: cnt_d = alu_d;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      prev_q   <= '0;
      cur_q    <= '0;
      result_q <= '0;
`ifdef FIBO_OVF_EN
      cur_wrap_q  <= 1'b0;
      prev_wrap_q <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      cur_q    <= cur_d;
      result_q <= result_d;
`ifdef FIBO_OVF_EN
      cur_wrap_q  <= cur_wrap_d;
      prev_wrap_q <= prev_wrap_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign result = result_q;
`ifdef FIBO_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule
